mat_stream_out: RTL
===================

MAT_STREAM_OUT -- requirements
Module: mat_stream_out

Interface
REQ-001 Parameter DATA_WIDTH, default 16, element width (Q8.8 fixed point).
REQ-002 Parameter ROW, default 8, matrix rows.
REQ-003 Parameter COL, default 8, matrix columns.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  packed matrix on in_data is valid.
REQ-007 in_ready  output  1  block can accept a new matrix.
REQ-008 in_data  input  DATA_WIDTH*ROW*COL  packed matrix; element (i,j) at bits [DATA_WIDTH*(i*COL+j+1)-1 : DATA_WIDTH*(i*COL+j)], the same layout MatSoftmax drives.
REQ-009 out_valid  output  1  out_data holds a valid element.
REQ-010 out_ready  input  1  downstream accepts the element.
REQ-011 out_data  output  DATA_WIDTH  current element.
REQ-012 out_row  output  $clog2(ROW)  row index of out_data.
REQ-013 out_col  output  $clog2(COL)  column index of out_data.
REQ-014 out_last_col  output  1  out_data is the last element of its row (out_col == COL-1).
REQ-015 out_last  output  1  out_data is element (ROW-1,COL-1).

Function
REQ-016 The block SHALL have two states: IDLE and STREAM.
REQ-017 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in STREAM, in_ready SHALL be 0.
REQ-018 When in_valid && in_ready at edge N, in_data SHALL be captured into an internal register, and the state SHALL be STREAM with element (0,0) on out_data and out_valid=1 from cycle N+1.
REQ-019 Elements SHALL be emitted row-major: (0,0),(0,1)..(0,COL-1),(1,0)..(ROW-1,COL-1).
REQ-020 A beat transfers only when out_valid && out_ready; the index then advances by one element on that edge.
REQ-021 While out_valid && !out_ready, out_data, out_row, out_col, out_last_col and out_last SHALL hold stable.
REQ-022 Changes on in_data or in_valid during STREAM SHALL NOT affect the emitted data.
REQ-023 On transfer of the out_last beat, the state SHALL return to IDLE: out_valid=0 and in_ready=1 on the next cycle. A full matrix therefore takes ROW*COL beats plus one idle cycle.
REQ-024 With out_ready held 1, one element SHALL transfer per cycle with no bubbles inside a matrix.
REQ-025 The element counter SHALL be $clog2(ROW*COL) bits wide. It SHALL wrap to 0 only on the out_last transfer and never exceed ROW*COL-1.
REQ-026 out_row and out_col SHALL be derived from counters or register state, not from division logic.
REQ-027 Data SHALL pass bit-exact with no arithmetic, sign change or saturation.

Reset
REQ-028 When rst_n=0 at a rising edge, the state SHALL be IDLE, the counters 0, and the outputs out_valid=0, out_data=0, out_row=0, out_col=0, out_last_col=0, out_last=0 and in_ready=1 on the following cycle.
REQ-029 Reset during STREAM SHALL abort the matrix; no further beats of it are emitted.
REQ-030 Reset SHALL take priority over a simultaneous input or output handshake.

Structure
REQ-031 Package mat_pkg SHALL hold the state encoding (IDLE=0, STREAM=1) and the default DATA_WIDTH/ROW/COL constants shared with MatSoftmax.
REQ-032 The block SHALL be one module with no sub-module. The row/column counter pair may later become mat_index_counter, shared with the matching input deserializer.

Verification
REQ-033 Load element k = k*256 (integer k in Q8.8), out_ready=1 -> 64 consecutive beats 0x0000..0x3F00; out_last_col on k=7,15..63; out_last only on k=63; in_ready=1 one cycle after k=63.
REQ-034 Same load, out_ready toggled 1,0,1,0 -> each element appears exactly once, in order; outputs are stable during every stall cycle.
REQ-035 in_valid held 1 with in_data changed every cycle -> only the matrix present at the accepting edge is emitted; the next matrix is accepted only in IDLE after out_last.
REQ-036 rst_n=0 for one cycle after beat 20 -> next cycle out_valid=0 and in_ready=1; a new load restarts at (0,0).
REQ-037 Back-to-back matrices A (all 0x0100) then B (all 0x0080) -> 64 beats of 0x0100, one idle cycle, then 64 beats of 0x0080.
REQ-038 ROW=2, COL=4 -> 8 beats; out_row/out_col sequence (0,0)..(1,3); out_last on (1,3).

Source files
------------

// File: rtl/mat_pkg.sv
// Shared constants and state encoding for the matrix stream blocks.
package mat_pkg;

    localparam int MAT_DATA_WIDTH = 16;
    localparam int MAT_ROW        = 8;
    localparam int MAT_COL        = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/mat_stream_out.sv
// Serializes a packed ROW x COL matrix into a row-major element stream
// with valid/ready handshakes on both sides.
module mat_stream_out
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH = MAT_DATA_WIDTH,
    parameter int ROW        = MAT_ROW,
    parameter int COL        = MAT_COL
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH*ROW*COL-1:0]  in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(ROW)-1:0]         out_row,
    output logic [$clog2(COL)-1:0]         out_col,
    output logic                           out_last_col,
    output logic                           out_last
);

    localparam int N   = ROW * COL;
    localparam int CW  = $clog2(N);
    localparam int RW  = $clog2(ROW);
    localparam int CLW = $clog2(COL);

    localparam logic [RW-1:0]  ROW_MAX = RW'(ROW - 1);
    localparam logic [CLW-1:0] COL_MAX = CLW'(COL - 1);

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            cnt_nxt;
    logic [RW-1:0]            row_nxt;
    logic [CLW-1:0]           col_nxt;
    logic [DATA_WIDTH*N-1:0]  mat;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == STREAM);

    // out_row/out_col are themselves the index counters; no division needed
    always_comb begin
        cnt_nxt = cnt + CW'(1);
        row_nxt = out_row;
        col_nxt = out_col + CLW'(1);
        if (out_last_col) begin
            col_nxt = '0;
            row_nxt = out_row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            mat          <= '0;
            out_data     <= '0;
            out_row      <= '0;
            out_col      <= '0;
            out_last_col <= 1'b0;
            out_last     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state        <= STREAM;
                        mat          <= in_data;
                        out_data     <= in_data[DATA_WIDTH-1:0];
                        cnt          <= '0;
                        out_row      <= '0;
                        out_col      <= '0;
                        out_last_col <= (COL == 1);
                        out_last     <= (N == 1);
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state        <= IDLE;
                            cnt          <= '0;
                            out_row      <= '0;
                            out_col      <= '0;
                            out_last_col <= 1'b0;
                            out_last     <= 1'b0;
                        end else begin
                            cnt          <= cnt_nxt;
                            out_data     <= mat[int'(cnt_nxt)*DATA_WIDTH +: DATA_WIDTH];
                            out_row      <= row_nxt;
                            out_col      <= col_nxt;
                            out_last_col <= (col_nxt == COL_MAX);
                            out_last     <= (col_nxt == COL_MAX) &&
                                            (row_nxt == ROW_MAX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
